// File: rtl/fp_pkg.sv
// Shared FP definitions: bias constants, converter state encoding and the
// round-to-nearest-even helper used by the conversion blocks.
package fp_pkg;

   localparam int unsigned FP32_BIAS       = 127;
   localparam int unsigned INT32_EXP_START = FP32_BIAS + 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } fsm_state_e;

   typedef struct packed {
      logic        carry;
      logic [22:0] frac;
      logic        inexact;
   } round_res_t;

   // mag must be normalised (bit 31 set); the hidden one is mag[31].
   // A carry-out means the mantissa wrapped to 1.0 and the exponent must bump.
   function automatic round_res_t round_rne(input logic [31:0] mag);
      round_res_t  r;
      logic        guard;
      logic        sticky;
      logic        up;
      logic [23:0] sum;
      guard     = mag[7];
      sticky    = |mag[6:0];
      up        = guard & (sticky | mag[8]);
      sum       = {1'b0, mag[30:8]} + {23'd0, up};
      r.carry   = sum[23];
      r.frac    = sum[22:0];
      r.inexact = guard | sticky;
      return r;
   endfunction

endpackage

// File: rtl/int_to_float.sv
// Iterative 32-bit signed/unsigned integer to fp32 converter, one normalise
// shift per cycle, RNE rounding, valid/ready on both sides, one op in flight.
module int_to_float
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_inexact
);

   fsm_state_e  state;
   logic        sign;
   logic [31:0] mag;
   logic [7:0]  exp_q;

   logic        in_neg;
   logic [31:0] in_mag;
   round_res_t  rr;

   // 0x80000000 signed negates to itself, which is the correct magnitude.
   assign in_neg = in_signed & in_data[31];
   assign in_mag = in_neg ? (~in_data + 32'd1) : in_data;
   assign rr     = round_rne(mag);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         sign        <= 1'b0;
         mag         <= '0;
         exp_q       <= '0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  sign     <= in_neg;
                  mag      <= in_mag;
                  exp_q    <= 8'(INT32_EXP_START);
                  if (in_mag == 32'd0) begin
                     out_data    <= '0;
                     out_inexact <= 1'b0;
                     out_valid   <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= NORM;
                  end
               end
            end
            NORM: begin
               if (mag[31]) begin
                  state <= ROUND;
               end else begin
                  mag   <= {mag[30:0], 1'b0};
                  exp_q <= exp_q - 8'd1;
               end
            end
            ROUND: begin
               // Exponent tops out at 159, so the carry can never overflow.
               out_data    <= {sign, exp_q + {7'd0, rr.carry}, rr.frac};
               out_inexact <= rr.inexact;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/int_to_float.md
# int_to_float

Sequential signed/unsigned 32-bit integer to IEEE-754 single-precision converter. It produces fp32 operands for the floating-point adder from integer register values and is the integer-to-float half of the FP conversion path. Normalisation is iterative, one bit per cycle, and rounding is round-to-nearest-even. Valid/ready handshakes sit on both sides, with one conversion in flight.

## Interface
- No parameters; widths are fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand; high only in IDLE
- in_data  in  32  integer operand
- in_signed  in  1  1: in_data is two's complement; 0: unsigned; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  fp32 result {sign, exp[7:0], frac[22:0]}
- out_inexact  out  1  result differs from the exact integer value

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE, accept when in_valid&in_ready:
  - sign = in_signed & in_data[31].
  - mag = sign ? -in_data : in_data, 32-bit unsigned. 0x80000000 signed gives mag 0x80000000.
  - exp = 158 (127+31).
  - mag==0 goes to DONE with out_data=0x00000000 and out_inexact=0.
  - Otherwise go to NORM.
- NORM:
  - mag[31]==0: mag <<= 1, exp -= 1, stay in NORM.
  - mag[31]==1: go to ROUND.
- ROUND:
  - frac = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up when guard & (sticky | frac[0]).
  - A frac carry-out sets frac=0 and exp += 1. Max exp is 159; overflow is impossible.
  - out_inexact = guard | sticky.
  - Go to DONE.
- DONE:
  - out_valid=1, with out_data and out_inexact held stable.
  - On out_valid&out_ready, go to IDLE.
- Denormals, NaN and Inf are never produced.
- Input fields are ignored outside IDLE.
- Reset, including mid-conversion, forces IDLE and drops the in-flight operand.
  - Reset values: in_ready=0 during reset and 1 the cycle after; out_valid=0, out_data=0, out_inexact=0.

## Timing
- Edge e0 is the accepting edge. L = leading zeros of mag (0..31).
- Nonzero operand:
  - NORM occupies edges e1..e(L+1).
  - ROUND is at e(L+2).
  - out_valid is first high after edge e(L+2).
  - Latency ranges from 2 edges (L=0) to 33 edges (L=31).
- Zero operand: out_valid is high after e0.
- Results are registered; there is no combinational in-to-out path.
- The output may complete at edge E (out_valid&out_ready). in_ready is then high after E, and the next accept is at E+1 at the earliest. No back-to-back overlap.
- Backpressure: out_valid stays high and out_data stays constant indefinitely while out_ready=0. in_ready stays low throughout.
- in_valid may drop without acceptance; nothing is latched unless the handshake completes.

## Structure
- Shared package fp_pkg holds:
  - FP32_BIAS=127
  - INT32_EXP_START=158
  - the state enum {IDLE, NORM, ROUND, DONE}
  - the rounding function: 32-bit normalised mag in, {carry, frac[22:0], inexact} out, reused later by other FP blocks.
- No sub-module; a single FSM plus datapath registers (sign, mag[31:0], exp[7:0]).

## Test plan
- Signed 0x00000001 -> 0x3F800000, inexact 0. out_valid first high after edge e33. Signed 0xFFFFFFFF (-1) -> 0xBF800000.
- 0x00000000 (signed or unsigned) -> 0x00000000, inexact 0. out_valid high after e0. Signed 0x80000000 -> 0xCF000000, inexact 0. Unsigned 0x80000000 -> 0x4F000000.
- Rounding:
  - Unsigned 0xFFFFFFFF -> 0x4F800000, inexact 1 (carry into exponent).
  - 0x01000001 -> 0x4B800000, inexact 1 (tie, even, round down).
  - 0x01000003 -> 0x4B800002, inexact 1 (tie, round up).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_data stays constant, in_ready stays 0, and a pending in_valid is not accepted. Release out_ready; the next operand is accepted one cycle later.
- Reset mid-NORM: accept 0x00000001, assert rst_n=0 at e5. The next cycle shows out_valid=0, out_data=0 and in_ready=0. After release, in_ready=1, and a fresh 0x00000003 converts to 0x40400000.
- Random regression of 10k operands with random in_signed and random in_valid/out_ready gaps, checked against a reference int-to-real rounding model for out_data, out_inexact and latency (L+2).
